// File: rtl/rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor: mode codes,
// per-stage control record and packing offsets for the triangular stage registers.
package rca_pkg;

    localparam logic RCA_ADD = 1'b0;
    localparam logic RCA_SUB = 1'b1;

    typedef struct packed {
        logic vld;
        logic cy;
    } rca_stage_t;

    // Stage k keeps (k+1) result chunks; stages are packed back to back.
    function automatic int unsigned rca_sum_off(input int unsigned k, input int unsigned chunk);
        return chunk * ((k * (k + 1)) / 2);
    endfunction

    // Stage k keeps (stages-1-k) pending operand chunks; stages are packed back to back.
    function automatic int unsigned rca_skew_off(input int unsigned k, input int unsigned stages,
                                                 input int unsigned chunk);
        int unsigned off;
        off = 0;
        for (int unsigned i = 0; i < k; i++) begin
            off += (stages - 1 - i) * chunk;
        end
        return off;
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple-carry slice built from full-adder equations.
module rca_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout     = w_c[CHUNK];
    assign c_msb_in = w_c[CHUNK-1];

endmodule

// File: rtl/pipelined_rca_addsub.sv
// Pipelined WIDTH-bit ripple-carry adder/subtractor, one CHUNK slice per stage,
// valid/ready streaming with a single global advance enable.
module pipelined_rca_addsub
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned STAGES    = WIDTH / CHUNK;
    localparam int unsigned SUM_BITS  = rca_sum_off(STAGES, CHUNK);
    localparam int unsigned SKEW_REAL = rca_skew_off(STAGES, STAGES, CHUNK);
    localparam int unsigned SKEW_BITS = (SKEW_REAL > 0) ? SKEW_REAL : 1;
    localparam int unsigned LAST_OFF  = rca_sum_off(STAGES - 1, CHUNK);

    logic                   w_adv;
    logic                   w_acc;
    logic [WIDTH-1:0]       w_b_eff;
    logic                   w_c0;
    logic [WIDTH-1:0]       w_sum;

    rca_stage_t [STAGES-1:0] r_stg;
    logic [SUM_BITS-1:0]    r_sum;
    logic [SKEW_BITS-1:0]   r_skew_a;
    logic [SKEW_BITS-1:0]   r_skew_b;
    logic                   r_cmsb;

    // Whole pipeline moves together unless the output is stalled.
    assign w_adv    = !r_stg[STAGES-1].vld || out_ready;
    assign w_acc    = in_valid && w_adv;
    assign in_ready = w_adv;

    assign w_b_eff = (sub == RCA_SUB) ? ~b : b;
    assign w_c0    = (sub == RCA_SUB) ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned SOFF = rca_sum_off(k, CHUNK);
        localparam int unsigned SW   = (k + 1) * CHUNK;
        localparam int unsigned KOFF = rca_skew_off(k, STAGES, CHUNK);
        localparam int unsigned KW   = (STAGES - 1 - k) * CHUNK;
        localparam int unsigned PW   = (STAGES - k) * CHUNK;

        logic [PW-1:0]    w_pa;
        logic [PW-1:0]    w_pb;
        logic             w_ci;
        logic             w_vin;
        logic [CHUNK-1:0] w_s;
        logic             w_co;
        logic             w_cm;
        logic [SW-1:0]    w_snext;

        if (k == 0) begin : g_in
            assign w_pa    = a;
            assign w_pb    = w_b_eff;
            assign w_ci    = w_c0;
            assign w_vin   = w_acc;
            assign w_snext = w_s;
        end else begin : g_mid
            localparam int unsigned PKOFF = rca_skew_off(k - 1, STAGES, CHUNK);
            localparam int unsigned PSOFF = rca_sum_off(k - 1, CHUNK);

            assign w_pa    = r_skew_a[PKOFF +: PW];
            assign w_pb    = r_skew_b[PKOFF +: PW];
            assign w_ci    = r_stg[k-1].cy;
            assign w_vin   = r_stg[k-1].vld;
            assign w_snext = {w_s, r_sum[PSOFF +: k * CHUNK]};
        end

        rca_chunk #(
            .CHUNK    (CHUNK)
        ) u_chunk (
            .a        (w_pa[CHUNK-1:0]),
            .b        (w_pb[CHUNK-1:0]),
            .cin      (w_ci),
            .sum      (w_s),
            .cout     (w_co),
            .c_msb_in (w_cm)
        );

        always_ff @(posedge clk or negedge rst_n) begin : p_stage
            if (!rst_n) begin
                r_stg[k]           <= '0;
                r_sum[SOFF +: SW]  <= '0;
            end else if (w_adv) begin
                r_stg[k].vld       <= w_vin;
                r_stg[k].cy        <= w_co;
                r_sum[SOFF +: SW]  <= w_snext;
            end
        end

        // Upper operand chunks travel alongside their partial result.
        if (KW > 0) begin : g_skew
            always_ff @(posedge clk or negedge rst_n) begin : p_skew
                if (!rst_n) begin
                    r_skew_a[KOFF +: KW] <= '0;
                    r_skew_b[KOFF +: KW] <= '0;
                end else if (w_adv) begin
                    r_skew_a[KOFF +: KW] <= w_pa[PW-1:CHUNK];
                    r_skew_b[KOFF +: KW] <= w_pb[PW-1:CHUNK];
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            always_ff @(posedge clk or negedge rst_n) begin : p_cmsb
                if (!rst_n) begin
                    r_cmsb <= 1'b0;
                end else if (w_adv) begin
                    r_cmsb <= w_cm;
                end
            end
        end else begin : g_drop
            logic w_cm_unused;
            assign w_cm_unused = w_cm;
        end
    end

    assign w_sum     = r_sum[LAST_OFF +: WIDTH];
    assign sum       = w_sum;
    assign out_valid = r_stg[STAGES-1].vld;
    assign cout      = r_stg[STAGES-1].cy;
    assign ovf       = r_cmsb ^ r_stg[STAGES-1].cy;
    assign zero      = (w_sum == '0);

endmodule

// File: tb/tb_pipelined_rca_addsub.sv
// Self-checking bench for pipelined_rca_addsub at WIDTH=16, CHUNK=4 (four stages).
module tb_pipelined_rca_addsub;
    import rca_pkg::*;

    localparam int unsigned W = 16;
    localparam int unsigned C = 4;
    localparam int unsigned S = W / C;

    typedef struct packed {
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } res_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          zero;

    int n_chk;
    int n_err;
    int cyc;
    res_t sb[$];
    int   out_cyc[$];
    vec_t vecs[9];

    pipelined_rca_addsub #(
        .WIDTH     (W),
        .CHUNK     (C)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic res_t model(input logic [15:0] ia, input logic [15:0] ib,
                                   input logic icin, input logic isub);
        res_t        r;
        int unsigned ua;
        int unsigned ub;
        int unsigned full;
        int          s;
        ua = 32'(ia);
        ub = 32'(ib);
        if (isub == RCA_SUB) begin
            r.s  = 16'(ua - ub);
            r.co = (ua >= ub);
            s    = int'($signed(ia)) - int'($signed(ib));
        end else begin
            full = ua + ub + 32'(icin);
            r.s  = full[15:0];
            r.co = full[16];
            s    = int'($signed(ia)) + int'($signed(ib)) + int'(icin);
        end
        r.ov = (s > 32767) || (s < -32768);
        r.z  = (r.s == 16'h0000);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] ia, input logic [15:0] ib,
                         input logic icin, input logic isub);
        in_valid = v;
        a        = ia;
        b        = ib;
        cin      = icin;
        sub      = isub;
    endtask

    // One clock: score the output handshake, log the input handshake, cross the edge.
    task automatic cycle();
        res_t e;
        #1;
        if (out_valid) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL spurious_out: out_valid=1 sum=%0h with nothing outstanding", sum);
            end else if (out_ready) begin
                e = sb.pop_front();
                chk("sb_sum", 32'(sum), 32'(e.s));
                chk("sb_cout", 32'(cout), 32'(e.co));
                chk("sb_ovf", 32'(ovf), 32'(e.ov));
                chk("sb_zero", 32'(zero), 32'(e.z));
                out_cyc.push_back(cyc);
            end
        end
        if (in_valid && in_ready) begin
            sb.push_back(model(a, b, cin, sub));
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input string nm);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() > 0; i++) cycle();
        chk(nm, 32'(sb.size()), 32'd0);
    endtask

    // Single beat into an empty pipe; result must appear exactly S edges later.
    task automatic run_vec(input vec_t v, input string nm);
        out_ready = 1'b1;
        drive(1'b1, v.a, v.b, v.cin, v.sub);
        cycle();
        in_valid = 1'b0;
        repeat (S - 2) cycle();
        chk({nm, "_early"}, 32'(out_valid), 32'd0);
        cycle();
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_sum"}, 32'(sum), 32'(v.s));
        chk({nm, "_cout"}, 32'(cout), 32'(v.co));
        chk({nm, "_ovf"}, 32'(ovf), 32'(v.ov));
        chk({nm, "_zero"}, 32'(zero), 32'(v.z));
        cycle();
    endtask

    initial begin
        logic pat [4];
        logic exp_ov;
        res_t e;

        n_chk = 0;
        n_err = 0;
        cyc   = 0;
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, RCA_ADD);

        //            a        b        cin   sub      sum      co    ov    z
        vecs[0] = '{16'h0001, 16'h0001, 1'b0, RCA_ADD, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0FFF, 16'h0001, 1'b0, RCA_ADD, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, RCA_ADD, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, RCA_SUB, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{16'h0003, 16'h0005, 1'b0, RCA_SUB, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, RCA_ADD, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{16'h0005, 16'h0005, 1'b1, RCA_SUB, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, RCA_ADD, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{16'h8000, 16'h8000, 1'b0, RCA_ADD, 16'h0000, 1'b1, 1'b1, 1'b1};

        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);

        for (int i = 1; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Bubbles: out_valid replays the in_valid pattern S edges later.
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0;
        for (int n = 1; n <= int'(S) + 5; n++) begin
            if (n <= 4) drive(pat[n-1], 16'(n * 257), 16'(n * 3), 1'b0, RCA_ADD);
            else in_valid = 1'b0;
            cycle();
            exp_ov = (n >= int'(S) && n < int'(S) + 4) ? pat[n - int'(S)] : 1'b0;
            chk($sformatf("bubble_ov%0d", n), 32'(out_valid), 32'(exp_ov));
        end
        drain("bubble_drain");

        // Back-to-back stream of 20 beats.
        out_cyc.delete();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            cycle();
        end
        drain("stream_drain");
        chk("stream_cnt", 32'(out_cyc.size()), 32'd20);
        if (out_cyc.size() == 20) chk("stream_gap", 32'(out_cyc[19] - out_cyc[0]), 32'd19);

        // Backpressure: stall a valid result for 5 cycles while offering a new beat.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        cycle();
        drive(1'b1, 16'h1234, 16'h4321, 1'b1, RCA_ADD);
        for (int i = 0; i < 5; i++) begin
            #1;
            e = sb[0];
            chk($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
            chk($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp_sum%0d", i), 32'(sum), 32'(e.s));
            chk($sformatf("bp_flags%0d", i), {29'd0, cout, ovf, zero}, {29'd0, e.co, e.ov, e.z});
            cycle();
        end
        out_cyc.delete();
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        drain("bp_drain");
        chk("bp_cnt", 32'(out_cyc.size()), 32'd4);
        if (out_cyc.size() == 4) chk("bp_gap", 32'(out_cyc[2] - out_cyc[0]), 32'd2);

        // Reset mid-stream discards in-flight beats.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0F0F, 16'(i + 1), 1'b0, RCA_ADD);
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        cycle();
        chk("prerst_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_zero", 32'(zero), 32'd1);
        chk("midrst_cout", 32'(cout), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk($sformatf("postrst_idle%0d", i), 32'(out_valid), 32'd0);
        end
        run_vec(vecs[0], "postrst");

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                  1'($urandom), 1'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain("rand_drain");
        chk("rand_idle", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_rca_addsub.md
# pipelined_rca_addsub

Parametrised, pipelined ripple-carry adder/subtractor. It is the next generation of the team's 4-bit combinational ripple-carry adder. WIDTH-bit operands are split into CHUNK-bit slices, one slice per pipeline stage, with the carry registered between stages. The block sits between operand producers and result consumers on valid/ready streams, sustains one operation per cycle, and adds subtract mode plus signed overflow and zero flags.

## Interface
Parameters:
- WIDTH, 32, operand and result width; must be an integer multiple of CHUNK
- CHUNK, 8, bits added per pipeline stage; STAGES = WIDTH/CHUNK (≥1)

Ports:
- clk  input  1  single clock, rising-edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept an operand beat this cycle
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- cin  input  1  carry-in; used only when sub=0
- sub  input  1  0: a+b+cin; 1: a−b (a + ~b + 1)
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry-out of MSB (sub=1: 1 means no borrow)
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB
- zero  output  1  sum == 0

## Operation
- The pipeline has STAGES registers, each with a valid bit. Stage k holds:
  - result chunks 0..k
  - the registered carry out of chunk k
  - the not-yet-added upper operand chunks k+1..STAGES−1, skewed forward
  - the carry into the MSB, captured in the last stage only
- Input stage: sub=1 inverts b and forces carry-in to 1; cin is ignored. Stage 0 adds chunk 0.
- Stage k (k≥1) adds chunk k of the skewed operands using the registered carry from stage k−1.
- Flags are computed from the final-stage registers:
  - cout and ovf come from the last slice.
  - zero is combinational on the registered sum.
- Flow control is a global enable: adv = !out_valid | out_ready.
  - in_ready = adv. A beat is accepted when in_valid && in_ready.
  - On adv, every stage shifts forward. Stage 0 loads the accepted beat, or a bubble (valid=0) when nothing is accepted.
  - When adv=0 all stage registers hold, including invalid ones. Bubbles are not squeezed out.
- Results leave in issue order. No operation is dropped or duplicated.

## Timing
- Latency: a beat accepted on edge N is presented with out_valid=1 after edge N+STAGES−1, i.e. STAGES cycles of pipeline, provided adv stays high.
- Throughput: 1 beat/cycle while out_ready=1.
- Backpressure:
  - out_valid=1 && out_ready=0 makes in_ready=0 in the same cycle, combinationally.
  - sum, cout, ovf and zero stay stable while out_valid=1 && out_ready=0.
- Simultaneous accept and output handshake in the same cycle is legal and is the steady-state case.
- Reset (rst_n=0, asynchronous, any cycle including mid-stream):
  - all valid bits, data and carry registers clear to 0
  - out_valid=0, sum=0, cout=0, ovf=0, zero=1
  - in_ready=1 after reset
  - in-flight beats are discarded
- Arithmetic wraps modulo 2^WIDTH, e.g. all-ones + 1 → sum=0, cout=1, zero=1.
- STAGES=1 degenerates to a single registered adder with latency 1.

## Structure
- Shared package rca_pkg:
  - mode constants RCA_ADD=1'b0 and RCA_SUB=1'b1
  - a typedef for the per-stage carry/valid record
- Sub-module rca_chunk: purely combinational CHUNK-bit ripple slice built from full-adder equations.
  - Inputs: a, b, cin
  - Outputs: sum, cout, and c_msb_in (carry into the slice MSB, for ovf)
- The top level generates STAGES rca_chunk instances plus the skew and valid registers.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 (latency 4).
- Reset mid-stream: 3 beats in flight, pulse rst_n low → out_valid=0, sum=0, zero=1 immediately; nothing emerges afterwards; the next beat 0x0001+0x0001 returns 0x0002.
- Chunk-crossing carry: a=0x0FFF, b=0x0001, cin=0, sub=0 → sum=0x1000, cout=0, ovf=0, exactly 4 cycles after accept. Also a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, zero=1.
- Subtract and overflow:
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1
  - a=0x0003, b=0x0005, sub=1 → sum=0xFFFE, cout=0, ovf=0
  - a=0x7FFF, b=0x0001, sub=0 → sum=0x8000, ovf=1
- Back-to-back stream: 20 random beats on consecutive cycles with out_ready=1 → 20 results on consecutive cycles, in order, matching the reference model.
- Backpressure: hold out_ready=0 for 5 cycles while a result is valid → in_ready=0, outputs frozen; on release, all queued results drain in order with no loss.
- Bubbles: in_valid toggled 1,0,1,0 → out_valid mirrors the pattern delayed by 4 cycles.
